// File: rtl/csa_acc_seq.sv
// Multi-operand accumulator: each accepted beat is folded into a carry-save
// pair (S, C) by csa_tree, and one carry-propagate add resolves the job sum.

module csa_tree #(
  parameter int SIZE_I = 48,
  parameter int DEPTH  = 6
) (
  input  logic [SIZE_I-1:0] a [DEPTH],
  output logic [SIZE_I-1:0] b [2]
);

  // Chain of 3:2 compressors; every level keeps s+c equal to the running total.
  logic [SIZE_I-1:0] s_lvl [1:DEPTH-1];
  logic [SIZE_I-1:0] c_lvl [1:DEPTH-1];

  assign s_lvl[1] = a[0];
  assign c_lvl[1] = a[1];

  for (genvar g = 2; g < DEPTH; g++) begin : g_lvl
    logic [SIZE_I-1:0] maj;
    assign maj      = (s_lvl[g-1] & c_lvl[g-1]) | (s_lvl[g-1] & a[g]) | (c_lvl[g-1] & a[g]);
    assign s_lvl[g] = s_lvl[g-1] ^ c_lvl[g-1] ^ a[g];
    assign c_lvl[g] = {maj[SIZE_I-2:0], 1'b0};
  end

  assign b[0] = s_lvl[DEPTH-1];
  assign b[1] = c_lvl[DEPTH-1];

endmodule

// state   | meaning
// IDLE    | waiting for start; no job in flight
// ACC     | accepting beats, folding each into S/C
// RESOLVE | one cycle computing out_sum = S + C
// OUT     | result presented until out_ready
module csa_acc_seq #(
  parameter int SIZE_I = 32,
  parameter int LANES  = 4,
  parameter int SIZE_O = 48,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_beats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE_I-1:0] in_data [0:LANES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE_O-1:0] out_sum,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int DEPTH = LANES + 2;

  state_t            state;
  logic [SIZE_O-1:0] s_q;
  logic [SIZE_O-1:0] c_q;
  logic [CNT_W-1:0]  remain;
  logic [SIZE_O-1:0] tree_in  [DEPTH];
  logic [SIZE_O-1:0] tree_out [2];
  logic              accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign tree_in[i] = SIZE_O'(in_data[i]);
  end
  assign tree_in[LANES]   = s_q;
  assign tree_in[LANES+1] = c_q;

  csa_tree #(
    .SIZE_I (SIZE_O),
    .DEPTH  (DEPTH)
  ) u_tree (
    .a (tree_in),
    .b (tree_out)
  );

  // in_ready is a registered copy of (state == ACC), so it gates acceptance directly.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      c_q       <= '0;
      remain    <= '0;
      out_sum   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_q    <= '0;
            c_q    <= '0;
            remain <= num_beats;
            busy   <= 1'b1;
            if (num_beats != '0) begin
              state    <= ACC;
              in_ready <= 1'b1;
            end else begin
              state <= RESOLVE;
            end
          end
        end
        ACC: begin
          if (accept) begin
            s_q    <= tree_out[0];
            c_q    <= tree_out[1];
            remain <= remain - 1'b1;
            if (remain == CNT_W'(1)) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= s_q + c_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc_seq.sv
// Randomized self-checking bench for csa_acc_seq against a plain-sum model.

module tb_csa_acc_seq;

  localparam int SIZE_I = 32;
  localparam int LANES  = 4;
  localparam int SIZE_O = 48;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_beats;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE_I-1:0] in_data [0:LANES-1];
  logic              out_valid;
  logic              out_ready;
  logic [SIZE_O-1:0] out_sum;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [SIZE_I-1:0] beats [0:15][0:LANES-1];

  csa_acc_seq #(
    .SIZE_I (SIZE_I),
    .LANES  (LANES),
    .SIZE_O (SIZE_O),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_beats (num_beats),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain sum of every lane of every beat, mod 2^SIZE_O.
  function automatic logic [SIZE_O-1:0] model_sum(input int nb);
    logic [SIZE_O-1:0] acc;
    acc = '0;
    for (int b = 0; b < nb; b++)
      for (int l = 0; l < LANES; l++)
        acc = acc + SIZE_O'(beats[b][l]);
    return acc;
  endfunction

  task automatic set_beat(input int b, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
    beats[b][0] = v0;
    beats[b][1] = v1;
    beats[b][2] = v2;
    beats[b][3] = v3;
  endtask

  task automatic rand_beats(input int nb);
    for (int b = 0; b < nb; b++)
      for (int l = 0; l < LANES; l++)
        beats[b][l] = $urandom();
  endtask

  // Runs a full job from IDLE; called and returning at a falling edge.
  task automatic run_job(input int nb, input bit gaps, input int stall, input bit poke_start);
    logic [SIZE_O-1:0] exp;
    logic [SIZE_O-1:0] held;
    int idx;
    int budget;
    exp = model_sum(nb);
    start     = 1'b1;
    num_beats = CNT_W'(nb);
    cyc();
    start     = 1'b0;
    num_beats = CNT_W'($urandom_range(0, 9));
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    idx = 0;
    budget = 0;
    while (idx < nb && budget < 1000) begin
      chk("in_ready_acc", {63'd0, in_ready}, 64'd1);
      chk("out_valid_acc", {63'd0, out_valid}, 64'd0);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int l = 0; l < LANES; l++) in_data[l] = beats[idx][l];
      start = poke_start && (idx == 1);
      if (in_valid) idx++;
      cyc();
      start = 1'b0;
      budget++;
    end
    if (idx < nb) chk("beat_timeout", 64'(idx), 64'(nb));
    in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) in_data[l] = 32'hDEAD_BEEF;
    chk("in_ready_resolve", {63'd0, in_ready}, 64'd0);
    chk("out_valid_resolve", {63'd0, out_valid}, 64'd0);
    chk("busy_resolve", {63'd0, busy}, 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("out_valid_out", {63'd0, out_valid}, 64'd1);
    chk("out_sum", 64'(out_sum), 64'(exp));
    held = out_sum;
    for (int k = 0; k < stall; k++) begin
      cyc();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_sum", 64'(out_sum), 64'(held));
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
    chk("busy_after_hs", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    num_beats = 16'd3;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) in_data[l] = '0;
    repeat (3) cyc();
    start = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);

    // single beat {1,2,3,4} -> 10
    set_beat(0, 1, 2, 3, 4);
    run_job(1, 1'b0, 0, 1'b0);

    // three saturated beats -> 0xBFFFFFFF4
    for (int b = 0; b < 3; b++) set_beat(b, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_job(3, 1'b0, 0, 1'b0);
    chk("sat_sum_const", 64'(out_sum), 64'h0000_000B_FFFF_FFF4);

    // zero-length job
    run_job(0, 1'b0, 2, 1'b0);

    // stalls, backpressure and ignored start -> 40
    for (int b = 0; b < 4; b++) set_beat(b, b + 1, b + 1, b + 1, b + 1);
    run_job(4, 1'b1, 10, 1'b1);
    chk("stall_sum_const", 64'(out_sum), 64'd40);

    // reset mid-job, then a clean 1-beat job
    rand_beats(2);
    start = 1'b1;
    num_beats = 16'd5;
    cyc();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int l = 0; l < LANES; l++) in_data[l] = beats[b][l];
      cyc();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_out_sum", 64'(out_sum), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    set_beat(0, 5, 0, 0, 0);
    run_job(1, 1'b0, 0, 1'b0);
    chk("abort_next_sum", 64'(out_sum), 64'd5);

    // random jobs
    for (int j = 0; j < 12; j++) begin
      int nb;
      nb = $urandom_range(0, 12);
      rand_beats(nb);
      run_job(nb, j[0], $urandom_range(0, 4), j[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
